// File: rtl/edge_time_decoder.sv
// edge_time_decoder
// Turns rising-edge temporal codes into per-lane spike times, one result per
// gamma cycle, and presents each result through a one-entry valid/ready buffer.
// Build option: define EDGE_DECODE_WTA_EN to include the earliest-lane
// (winner-take-all) logic. Without it, winner_idx and winner_valid are tied to 0.
module edge_time_decoder #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int NUM_INPUTS        = 16,
    parameter int TIME_W            = $clog2(GAMMA_CYCLE_WIDTH + 1),
    parameter int IDX_W             = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    localparam int CNT_W            = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                         aclk,
    input  logic                         grst_n,
    input  logic [NUM_INPUTS-1:0]        inputs,
    output logic [CNT_W-1:0]             gamma_cnt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_INPUTS*TIME_W-1:0] out_times,
    output logic [IDX_W-1:0]             winner_idx,
    output logic                         winner_valid,
    output logic                         overflow
);

    localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [TIME_W-1:0] NO_SPIKE  = TIME_W'(GAMMA_CYCLE_WIDTH);

    logic [CNT_W-1:0]             gamma_cnt_reg;
    logic [CNT_W-1:0]             gamma_cnt_next;
    logic                         end_of_cycle;

    logic                         captured_reg  [NUM_INPUTS];
    logic [TIME_W-1:0]            lane_time_reg [NUM_INPUTS];

    // Times as they would read if the cycle ended on this edge: includes the
    // current slot's samples, so the last slot is never lost at the wrap.
    logic [NUM_INPUTS*TIME_W-1:0] result_times;

    logic [IDX_W-1:0]             win_idx_next;
    logic                         win_valid_next;

    logic                         out_valid_reg;
    logic [NUM_INPUTS*TIME_W-1:0] out_times_reg;
    logic [IDX_W-1:0]             winner_idx_reg;
    logic                         winner_valid_reg;
    logic                         overflow_reg;
    logic                         load_buffer;

    assign end_of_cycle = (gamma_cnt_reg == LAST_SLOT);

    // Next slot: wrap from the last slot back to zero.
    always_comb begin
        gamma_cnt_next = gamma_cnt_reg + CNT_W'(1);
        if (end_of_cycle) begin
            gamma_cnt_next = '0;
        end
    end

    // Slot counter register.
    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            gamma_cnt_reg <= '0;
        end else begin
            gamma_cnt_reg <= gamma_cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
            // Record the first high slot of the cycle; flags clear at the wrap so
            // a lane still high at slot 0 is captured again with time 0.
            always_ff @(posedge aclk or negedge grst_n) begin
                if (!grst_n) begin
                    captured_reg[gi]  <= 1'b0;
                    lane_time_reg[gi] <= NO_SPIKE;
                end else if (end_of_cycle) begin
                    captured_reg[gi]  <= 1'b0;
                end else if (inputs[gi] && !captured_reg[gi]) begin
                    captured_reg[gi]  <= 1'b1;
                    lane_time_reg[gi] <= TIME_W'(gamma_cnt_reg);
                end
            end

            assign result_times[gi*TIME_W +: TIME_W] =
                captured_reg[gi] ? lane_time_reg[gi] :
                (inputs[gi] ? TIME_W'(gamma_cnt_reg) : NO_SPIKE);
        end
    endgenerate

`ifdef EDGE_DECODE_WTA_EN
    logic [TIME_W-1:0] best_time;

    // Earliest lane wins; strict compare keeps the lowest index on ties.
    always_comb begin
        best_time      = NO_SPIKE;
        win_idx_next   = '0;
        win_valid_next = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (result_times[i*TIME_W +: TIME_W] < best_time) begin
                best_time      = result_times[i*TIME_W +: TIME_W];
                win_idx_next   = IDX_W'(i);
                win_valid_next = 1'b1;
            end
        end
    end
`else
    assign win_idx_next   = '0;
    assign win_valid_next = 1'b0;
`endif

    // A finished result enters the buffer if it is empty or being drained now.
    assign load_buffer = end_of_cycle && (!out_valid_reg || out_ready);

    // One-entry output buffer with sticky overflow on a dropped result.
    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            out_valid_reg    <= 1'b0;
            out_times_reg    <= {NUM_INPUTS{NO_SPIKE}};
            winner_idx_reg   <= '0;
            winner_valid_reg <= 1'b0;
            overflow_reg     <= 1'b0;
        end else begin
            if (load_buffer) begin
                out_valid_reg    <= 1'b1;
                out_times_reg    <= result_times;
                winner_idx_reg   <= win_idx_next;
                winner_valid_reg <= win_valid_next;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg    <= 1'b0;
            end
            if (end_of_cycle && !load_buffer) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign gamma_cnt    = gamma_cnt_reg;
    assign out_valid    = out_valid_reg;
    assign out_times    = out_times_reg;
    assign winner_idx   = winner_idx_reg;
    assign winner_valid = winner_valid_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_edge_time_decoder.sv
// Bench for edge_time_decoder: directed cases followed by random cycles, all
// checked against a cycle-level model that derives spike times from the
// recorded input history of each gamma cycle.
module tb_edge_time_decoder;

    localparam int G  = 16;
    localparam int NI = 16;
    localparam int TW = 5;
    localparam int IW = 4;

    logic              aclk = 1'b0;
    logic              grst_n;
    logic [NI-1:0]     inputs;
    logic [3:0]        gamma_cnt;
    logic              out_valid;
    logic              out_ready;
    logic [NI*TW-1:0]  out_times;
    logic [IW-1:0]     winner_idx;
    logic              winner_valid;
    logic              overflow;

    edge_time_decoder #(
        .GAMMA_CYCLE_WIDTH(G),
        .NUM_INPUTS(NI)
    ) dut (
        .aclk(aclk),
        .grst_n(grst_n),
        .inputs(inputs),
        .gamma_cnt(gamma_cnt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_times(out_times),
        .winner_idx(winner_idx),
        .winner_valid(winner_valid),
        .overflow(overflow)
    );

    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Model state
    int            cnt_m;
    logic [NI-1:0] hist [G];
    bit            v_m;
    bit            ov_m;
    int            t_m [NI];
    int            widx_m;
    bit            wv_m;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NI*TW-1:0] pack_times();
        logic [NI*TW-1:0] p;
        for (int i = 0; i < NI; i++) p[i*TW +: TW] = TW'(t_m[i]);
        return p;
    endfunction

    task automatic model_reset();
        cnt_m = 0; v_m = 0; ov_m = 0; widx_m = 0; wv_m = 0;
        for (int i = 0; i < NI; i++) t_m[i] = G;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cnt"}, 80'(gamma_cnt), 80'(0));
        chk({tag, "_valid"}, 80'(out_valid), 80'(0));
        chk({tag, "_times"}, 80'(out_times), 80'({NI{5'(G)}}));
        chk({tag, "_widx"}, 80'(winner_idx), 80'(0));
        chk({tag, "_wvalid"}, 80'(winner_valid), 80'(0));
        chk({tag, "_ovf"}, 80'(overflow), 80'(0));
    endtask

    // One clock edge: drive, advance the model, compare.
    task automatic step(input logic [NI-1:0] in_v, input logic rdy);
        int r [NI];
        inputs    = in_v;
        out_ready = rdy;
        @(posedge aclk);
        hist[cnt_m] = in_v;
        if (cnt_m == G - 1) begin
            for (int i = 0; i < NI; i++) begin
                r[i] = G;
                for (int s = 0; s < G; s++)
                    if (hist[s][i] && r[i] == G) r[i] = s;
            end
            if (!v_m || rdy) begin
                v_m = 1;
                for (int i = 0; i < NI; i++) t_m[i] = r[i];
                widx_m = 0; wv_m = 0;
`ifdef EDGE_DECODE_WTA_EN
                for (int i = 0; i < NI; i++)
                    if (r[i] < G && (!wv_m || r[i] < r[widx_m])) begin
                        widx_m = i; wv_m = 1;
                    end
`endif
                txn++;
                $display("txn %0d loaded widx=%0d wvalid=%0d t0=%0d t5=%0d", txn, widx_m, wv_m, r[0], r[5]);
            end else begin
                ov_m = 1;
            end
        end else if (v_m && rdy) begin
            v_m = 0;
        end
        cnt_m = (cnt_m + 1) % G;
        #1;
        chk("gamma_cnt", 80'(gamma_cnt), 80'(cnt_m));
        chk("out_valid", 80'(out_valid), 80'(v_m));
        chk("overflow", 80'(overflow), 80'(ov_m));
        if (v_m) begin
            chk("out_times", 80'(out_times), 80'(pack_times()));
            chk("winner_idx", 80'(winner_idx), 80'(widx_m));
            chk("winner_valid", 80'(winner_valid), 80'(wv_m));
        end
    endtask

    initial begin
        logic [NI-1:0] v;
        int lanes1 [7] = '{10, 1, 6, 8, 2, 4, 15};

        grst_n = 1'b0; inputs = '0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        check_reset_values("reset");
        grst_n = 1'b1;

        // Basic decode: lanes rise at successive slots and stay high.
        v = '0;
        for (int s = 0; s < G; s++) begin
            if (s < 7) v[lanes1[s]] = 1'b1;
            step(v, 1'b1);
        end

        // Tie at slot 5 and a lane rising in the final slot.
        for (int s = 0; s < G; s++) begin
            v = '0;
            if (s >= 5) begin v[3] = 1'b1; v[7] = 1'b1; end
            if (s == 15) v[0] = 1'b1;
            step(v, 1'b1);
        end

        // Empty cycle.
        for (int s = 0; s < G; s++) step('0, 1'b1);

        // Backpressure across two cycle ends, then a single accepting edge.
        for (int c = 0; c < 2; c++)
            for (int s = 0; s < G; s++) begin
                v = '0;
                if (s >= 2 + c) v[9 + c] = 1'b1;
                step(v, 1'b0);
            end
        step('0, 1'b1);
        for (int s = 1; s < G; s++) step('0, 1'b1);

        // Carry-over of a held lane and a one-cycle glitch.
        for (int s = 0; s < G; s++) begin
            v = '0;
            if (s >= 10) v[5] = 1'b1;
            if (s == 3) v[2] = 1'b1;
            step(v, 1'b1);
        end
        for (int s = 0; s < G; s++) begin
            v = '0;
            if (s <= 3) v[5] = 1'b1;
            if (s >= 12) v[1] = 1'b1;
            step(v, 1'b1);
        end

        // Reset mid-cycle while a result is held.
        for (int s = 0; s < 8; s++) step('0, 1'b0);
        chk("pre_reset_valid", 80'(out_valid), 80'(1));
        #2 grst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        @(posedge aclk);
        #1 grst_n = 1'b1;
        step('0, 1'b1);

        // Random cycles with sparse lanes and random backpressure.
        for (int s = 1; s < G; s++) step('0, 1'b1);
        for (int c = 0; c < 12; c++)
            for (int s = 0; s < G; s++) begin
                v = NI'($urandom & $urandom & $urandom);
                step(v, $urandom_range(0, 3) != 0);
            end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
